// File: rtl/ds_rx.sv
// ds_rx: IEEE 1355 data-strobe receiver.
// Brings the asynchronous D/S pair into the clk domain and recovers one bit
// per D^S transition. It deframes parity/flag/body characters and delivers
// each one as a single-cycle strobe with sticky parity and disconnect errors.
// Build option: define DS_RX_PARITY_EN to enable parity accumulation and
// checking. Without it the P bit is only consumed for framing and par_err is 0.
module ds_rx #(
  parameter int DISC_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_en,
  input  logic       d_in,
  input  logic       s_in,
  output logic       char_valid,
  output logic       char_ctrl,
  output logic [7:0] char_data,
  output logic       par_err,
  output logic       disc_err,
  output logic       rx_active
);

  localparam int CW = $clog2(DISC_CYCLES + 1);
  localparam logic [CW-1:0] DISC_M1 = CW'(DISC_CYCLES - 1);

  // Each state names the field that the next bit event belongs to.
  // The event that leaves IDLE is itself the P bit of the first character.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_HDR_P = 2'd1;
  localparam logic [1:0] ST_HDR_F = 2'd2;
  localparam logic [1:0] ST_BODY  = 2'd3;

  logic          d_meta_r, s_meta_r, d_sync_r, s_sync_r, xor_prev_r;
  logic          bit_evt_s, bit_val_s, body_last_s, disc_hit_s;
  logic [1:0]    state_r;
  logic [2:0]    bit_idx_r;
  logic [7:0]    shf_r, shf_next_s;
  logic          f_r;
  logic [CW-1:0] disc_cnt_r;
  logic          char_valid_r, char_ctrl_r, disc_err_r, rx_active_r;
  logic [7:0]    char_data_r;

  // Two-flop synchronisers plus the previous D^S level used for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_meta_r   <= 1'b0;
      s_meta_r   <= 1'b0;
      d_sync_r   <= 1'b0;
      s_sync_r   <= 1'b0;
      xor_prev_r <= 1'b0;
    end else begin
      d_meta_r   <= d_in;
      s_meta_r   <= s_in;
      d_sync_r   <= d_meta_r;
      s_sync_r   <= s_meta_r;
      xor_prev_r <= d_sync_r ^ s_sync_r;
    end
  end

  // Bit event decode, body position, next shift value and disconnect detect
  always_comb begin
    bit_evt_s = (d_sync_r ^ s_sync_r) ^ xor_prev_r;
    bit_val_s = d_sync_r;
    if (f_r) begin
      body_last_s = (bit_idx_r == 3'd1);
    end else begin
      body_last_s = (bit_idx_r == 3'd7);
    end
    shf_next_s            = shf_r;
    shf_next_s[bit_idx_r] = bit_val_s;
    disc_hit_s = (state_r != ST_IDLE) && !bit_evt_s && (disc_cnt_r >= DISC_M1);
  end

  // Character framing FSM, disconnect counter and registered outputs.
  // The counter never passes DISC_CYCLES-1 because the hit returns it to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      bit_idx_r    <= 3'd0;
      shf_r        <= 8'd0;
      f_r          <= 1'b0;
      disc_cnt_r   <= {CW{1'b0}};
      char_valid_r <= 1'b0;
      char_ctrl_r  <= 1'b0;
      char_data_r  <= 8'd0;
      disc_err_r   <= 1'b0;
      rx_active_r  <= 1'b0;
    end else begin
      char_valid_r <= 1'b0;
      if (!rx_en) begin
        state_r     <= ST_IDLE;
        bit_idx_r   <= 3'd0;
        disc_cnt_r  <= {CW{1'b0}};
        disc_err_r  <= 1'b0;
        rx_active_r <= 1'b0;
      end else if (bit_evt_s) begin
        disc_cnt_r <= {CW{1'b0}};
        case (state_r)
          ST_IDLE: begin
            rx_active_r <= 1'b1;
            state_r     <= ST_HDR_F;
          end
          ST_HDR_P: begin
            state_r <= ST_HDR_F;
          end
          ST_HDR_F: begin
            f_r       <= bit_val_s;
            bit_idx_r <= 3'd0;
            shf_r     <= 8'd0;
            state_r   <= ST_BODY;
          end
          ST_BODY: begin
            shf_r <= shf_next_s;
            if (body_last_s) begin
              char_valid_r <= 1'b1;
              char_ctrl_r  <= f_r;
              char_data_r  <= shf_next_s;
              bit_idx_r    <= 3'd0;
              state_r      <= ST_HDR_P;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
            end
          end
          default: begin
            state_r <= ST_IDLE;
          end
        endcase
      end else if (disc_hit_s) begin
        disc_err_r <= 1'b1;
        state_r    <= ST_IDLE;
        bit_idx_r  <= 3'd0;
        disc_cnt_r <= {CW{1'b0}};
      end else if (state_r != ST_IDLE) begin
        disc_cnt_r <= disc_cnt_r + CW'(1'b1);
      end else begin
        disc_cnt_r <= {CW{1'b0}};
      end
    end
  end

`ifdef DS_RX_PARITY_EN
  logic par_acc_r, par_err_r, first_char_r;

  // Odd parity covers the previous body plus the current P and F bits
  function automatic logic par_fold(input logic acc, input logic b);
    return acc ^ b;
  endfunction

  // Parity accumulation and the sticky check made at each F bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_acc_r    <= 1'b0;
      par_err_r    <= 1'b0;
      first_char_r <= 1'b1;
    end else if (!rx_en) begin
      par_acc_r    <= 1'b0;
      par_err_r    <= 1'b0;
      first_char_r <= 1'b1;
    end else if (bit_evt_s) begin
      case (state_r)
        ST_HDR_F: begin
          if (!first_char_r && !par_fold(par_acc_r, bit_val_s)) begin
            par_err_r <= 1'b1;
          end else begin
            par_err_r <= par_err_r;
          end
          par_acc_r    <= 1'b0;
          first_char_r <= 1'b0;
        end
        ST_IDLE, ST_HDR_P, ST_BODY: begin
          par_acc_r <= par_fold(par_acc_r, bit_val_s);
        end
        default: begin
          par_acc_r <= 1'b0;
        end
      endcase
    end else if (disc_hit_s) begin
      first_char_r <= 1'b1;
    end else begin
      first_char_r <= first_char_r;
    end
  end

  assign par_err = par_err_r;
`else
  assign par_err = 1'b0;
`endif

  assign char_valid = char_valid_r;
  assign char_ctrl  = char_ctrl_r;
  assign char_data  = char_data_r;
  assign disc_err   = disc_err_r;
  assign rx_active  = rx_active_r;

endmodule

// File: tb/tb_ds_rx.sv
// Directed bench for ds_rx: a DS-encoding driver plays a table of characters
// (hand-computed P bits and expected errors), plus hand-written sequences for
// rx_en drop mid-character and a link disconnect.
module tb_ds_rx;

`ifdef DS_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, rx_en, d_pin, s_pin;
  logic       char_valid, char_ctrl, par_err, disc_err, rx_active;
  logic [7:0] char_data;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic       ctrl;  // F bit
    logic [7:0] data;  // byte, or control code in [1:0]
    logic       p;     // P bit sent on the wire
    logic       perr;  // expected par_err after F (parity build)
    logic       disc;  // expected disc_err during this character
  } vec_t;

  vec_t       vecs [18];
  logic [8:0] rxq [$];

  ds_rx #(.DISC_CYCLES(64)) dut (
    .clk(clk), .rst_n(rst_n), .rx_en(rx_en), .d_in(d_pin), .s_in(s_pin),
    .char_valid(char_valid), .char_ctrl(char_ctrl), .char_data(char_data),
    .par_err(par_err), .disc_err(disc_err), .rx_active(rx_active)
  );

  always #5 clk = ~clk;

  // Capture every delivered character; a wider pulse shows up as an extra entry
  always @(negedge clk) begin
    if (rst_n && char_valid) rxq.push_back({char_ctrl, char_data});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // DS encoding: D carries the bit, S toggles when D does not change; 6-clock period
  task automatic send_bit(input logic b);
    @(negedge clk);
    if (b != d_pin) d_pin = b;
    else s_pin = ~s_pin;
    repeat (5) @(negedge clk);
  endtask

  task automatic run_vec(input int i);
    vec_t       v;
    logic [8:0] got;
    int         len;
    v   = vecs[i];
    len = v.ctrl ? 2 : 8;
    send_bit(v.p);
    send_bit(v.ctrl);
    check($sformatf("par_err_after_F[%0d]", i), 32'(par_err), 32'(PAR_EN ? v.perr : 1'b0));
    for (int k = 0; k < len; k++) send_bit(v.data[k]);
    check($sformatf("char_count[%0d]", i), 32'(rxq.size()), 32'd1);
    if (rxq.size() > 0) begin
      got = rxq.pop_front();
      check($sformatf("char_ctrl[%0d]", i), 32'(got[8]), 32'(v.ctrl));
      check($sformatf("char_data[%0d]", i), 32'(got[7:0]), 32'(v.data));
    end
    rxq.delete();
    check($sformatf("disc_err[%0d]", i), 32'(disc_err), 32'(v.disc));
    check($sformatf("rx_active[%0d]", i), 32'(rx_active), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; rx_en = 1'b0; d_pin = 1'b0; s_pin = 1'b0;
    //             ctrl  data   p     perr  disc
    vecs[0]  = '{1'b0, 8'hA5, 1'b0, 1'b0, 1'b0};  // first char, unchecked
    vecs[1]  = '{1'b0, 8'h3C, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 8'h3C, 1'b0, 1'b1, 1'b0};  // even -> parity error
    vecs[3]  = '{1'b0, 8'h81, 1'b1, 1'b1, 1'b0};  // still delivered, sticky
    vecs[4]  = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b0};  // EOP_1
    vecs[5]  = '{1'b1, 8'h03, 1'b1, 1'b1, 1'b0};  // ESC
    vecs[6]  = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0};  // FCC
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 8'hFF, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 8'hFF, 1'b0, 1'b0, 1'b0};  // first after rx_en cycle
    vecs[10] = '{1'b0, 8'h0A, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 8'h0C, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 8'h0E, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 8'h03, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 8'h05, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 8'h3C, 1'b0, 1'b0, 1'b1};  // first after disconnect
    vecs[16] = '{1'b0, 8'h81, 1'b1, 1'b0, 1'b1};
    vecs[17] = '{1'b0, 8'h81, 1'b0, 1'b1, 1'b1};  // checking resumed

    repeat (3) @(negedge clk);
    check("rst_char_valid", 32'(char_valid), 32'd0);
    check("rst_char_ctrl",  32'(char_ctrl),  32'd0);
    check("rst_char_data",  32'(char_data),  32'd0);
    check("rst_par_err",    32'(par_err),    32'd0);
    check("rst_disc_err",   32'(disc_err),   32'd0);
    check("rst_rx_active",  32'(rx_active),  32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    rx_en = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_vec(i);

    // Drop rx_en after P, F and three body bits
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    rx_en = 1'b0;
    repeat (2) @(negedge clk);
    check("en_drop_par_err",   32'(par_err),     32'd0);
    check("en_drop_disc_err",  32'(disc_err),    32'd0);
    check("en_drop_rx_active", 32'(rx_active),   32'd0);
    check("en_drop_no_char",   32'(rxq.size()),  32'd0);
    repeat (2) @(negedge clk);
    rx_en = 1'b1;
    @(negedge clk);

    for (int i = 9; i < 15; i++) run_vec(i);

    // Stop the link after five bits of a data character
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    repeat (55) @(negedge clk);
    check("disc_not_yet", 32'(disc_err), 32'd0);
    repeat (10) @(negedge clk);
    check("disc_set",     32'(disc_err),    32'd1);
    check("disc_no_char", 32'(rxq.size()),  32'd0);
    check("disc_par_err", 32'(par_err),     32'd0);

    for (int i = 15; i < 18; i++) run_vec(i);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
